// File: rtl/iommu_cq_decoder_if.sv
// Command-queue decoder bus: 64-bit beat stream in; IOTLB, directory-cache
// and fence request channels plus status flags out.
interface iommu_cq_decoder_if;
  logic        beat_valid_i;
  logic [63:0] beat_data_i;
  logic        beat_ready_o;

  logic        iotlb_inv_valid_o;
  logic        iotlb_inv_ready_i;
  logic        iotlb_inv_gvma_o;
  logic        iotlb_inv_av_o;
  logic        iotlb_inv_pscv_o;
  logic        iotlb_inv_gv_o;
  logic [19:0] iotlb_inv_pscid_o;
  logic [15:0] iotlb_inv_gscid_o;
  logic [51:0] iotlb_inv_vpn_o;

  logic        dir_inv_valid_o;
  logic        dir_inv_ready_i;
  logic        dir_inv_pdt_o;
  logic        dir_inv_dv_o;
  logic [23:0] dir_inv_did_o;
  logic [19:0] dir_inv_pid_o;

  logic        fence_valid_o;
  logic        fence_ready_i;
  logic        fence_av_o;
  logic        fence_wsi_o;
  logic        fence_pr_o;
  logic        fence_pw_o;
  logic [63:0] fence_addr_o;
  logic [31:0] fence_data_o;

  logic        cmd_done_o;
  logic        cmd_ill_o;
  logic        cmd_ill_clr_i;
  logic        busy_o;

  // Decoder side.
  modport slave (
    input  beat_valid_i, beat_data_i, iotlb_inv_ready_i, dir_inv_ready_i,
           fence_ready_i, cmd_ill_clr_i,
    output beat_ready_o,
           iotlb_inv_valid_o, iotlb_inv_gvma_o, iotlb_inv_av_o, iotlb_inv_pscv_o,
           iotlb_inv_gv_o, iotlb_inv_pscid_o, iotlb_inv_gscid_o, iotlb_inv_vpn_o,
           dir_inv_valid_o, dir_inv_pdt_o, dir_inv_dv_o, dir_inv_did_o, dir_inv_pid_o,
           fence_valid_o, fence_av_o, fence_wsi_o, fence_pr_o, fence_pw_o,
           fence_addr_o, fence_data_o,
           cmd_done_o, cmd_ill_o, busy_o
  );

  // Command source / request sink side.
  modport master (
    output beat_valid_i, beat_data_i, iotlb_inv_ready_i, dir_inv_ready_i,
           fence_ready_i, cmd_ill_clr_i,
    input  beat_ready_o,
           iotlb_inv_valid_o, iotlb_inv_gvma_o, iotlb_inv_av_o, iotlb_inv_pscv_o,
           iotlb_inv_gv_o, iotlb_inv_pscid_o, iotlb_inv_gscid_o, iotlb_inv_vpn_o,
           dir_inv_valid_o, dir_inv_pdt_o, dir_inv_dv_o, dir_inv_did_o, dir_inv_pid_o,
           fence_valid_o, fence_av_o, fence_wsi_o, fence_pr_o, fence_pw_o,
           fence_addr_o, fence_data_o,
           cmd_done_o, cmd_ill_o, busy_o
  );
endinterface

// File: rtl/iommu_cq_decoder.sv
// IOMMU command-queue decoder: assembles two 64-bit beats into one command and
// dispatches it to the IOTLB, directory-cache or fence request channel.
//
// state    | meaning
// IDLE     | waiting for beat0 (low dword)
// BEAT1    | low dword stored, waiting for beat1 (high dword)
// DISPATCH | exactly one request valid held until its ready
// HALT     | illegal command seen, waiting for cmd_ill_clr_i
module iommu_cq_decoder (
  input  logic              clk_i,
  input  logic              rst_i,
  iommu_cq_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BEAT1, DISPATCH, HALT} state_t;

  localparam logic [6:0] OP_IOTINVAL = 7'd1;
  localparam logic [6:0] OP_IOFENCE  = 7'd2;
  localparam logic [6:0] OP_IODIR    = 7'd3;
  localparam logic [2:0] F3_VMA      = 3'd0;
  localparam logic [2:0] F3_GVMA     = 3'd1;
  localparam logic [2:0] F3_DDT      = 3'd0;
  localparam logic [2:0] F3_PDT      = 3'd1;
  localparam logic [2:0] F3_FENCE_C  = 3'd0;

  state_t       state;
  logic [63:0]  lo_q;
  logic [127:0] cmd;
  logic [6:0]   opcode;
  logic [2:0]   func3;
  logic         is_iotlb;
  logic         is_dir;
  logic         is_fence;
  logic         dispatch_hs;
  logic         unused_cmd;

  always_comb begin
    cmd      = {bus.beat_data_i, lo_q};
    opcode   = cmd[6:0];
    func3    = cmd[9:7];
    is_iotlb = (opcode == OP_IOTINVAL) &&
               ((func3 == F3_VMA) || ((func3 == F3_GVMA) && !cmd[32]));
    is_dir   = (opcode == OP_IODIR) &&
               ((func3 == F3_DDT) || ((func3 == F3_PDT) && cmd[33]));
    is_fence = (opcode == OP_IOFENCE) && (func3 == F3_FENCE_C);
  end

  // Reserved command bits are deliberately dropped.
  assign unused_cmd = ^cmd;

  assign dispatch_hs = (bus.iotlb_inv_valid_o & bus.iotlb_inv_ready_i) |
                       (bus.dir_inv_valid_o   & bus.dir_inv_ready_i)   |
                       (bus.fence_valid_o     & bus.fence_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || (state == DISPATCH && dispatch_hs)) begin
      bus.iotlb_inv_valid_o <= 1'b0;
      bus.iotlb_inv_gvma_o  <= 1'b0;
      bus.iotlb_inv_av_o    <= 1'b0;
      bus.iotlb_inv_pscv_o  <= 1'b0;
      bus.iotlb_inv_gv_o    <= 1'b0;
      bus.iotlb_inv_pscid_o <= '0;
      bus.iotlb_inv_gscid_o <= '0;
      bus.iotlb_inv_vpn_o   <= '0;
      bus.dir_inv_valid_o   <= 1'b0;
      bus.dir_inv_pdt_o     <= 1'b0;
      bus.dir_inv_dv_o      <= 1'b0;
      bus.dir_inv_did_o     <= '0;
      bus.dir_inv_pid_o     <= '0;
      bus.fence_valid_o     <= 1'b0;
      bus.fence_av_o        <= 1'b0;
      bus.fence_wsi_o       <= 1'b0;
      bus.fence_pr_o        <= 1'b0;
      bus.fence_pw_o        <= 1'b0;
      bus.fence_addr_o      <= '0;
      bus.fence_data_o      <= '0;
    end
    if (rst_i) begin
      state            <= IDLE;
      lo_q             <= '0;
      bus.beat_ready_o <= 1'b1;
      bus.busy_o       <= 1'b0;
      bus.cmd_done_o   <= 1'b0;
      bus.cmd_ill_o    <= 1'b0;
    end else begin
      bus.cmd_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.beat_valid_i) begin
            lo_q       <= bus.beat_data_i;
            state      <= BEAT1;
            bus.busy_o <= 1'b1;
          end
        end
        BEAT1: begin
          if (bus.beat_valid_i) begin
            bus.beat_ready_o <= 1'b0;
            state            <= DISPATCH;
            if (is_iotlb) begin
              bus.iotlb_inv_valid_o <= 1'b1;
              bus.iotlb_inv_gvma_o  <= (func3 == F3_GVMA);
              bus.iotlb_inv_av_o    <= cmd[10];
              bus.iotlb_inv_pscv_o  <= cmd[32];
              bus.iotlb_inv_gv_o    <= cmd[33];
              bus.iotlb_inv_pscid_o <= cmd[31:12];
              bus.iotlb_inv_gscid_o <= cmd[59:44];
              bus.iotlb_inv_vpn_o   <= cmd[125:74];
            end else if (is_dir) begin
              bus.dir_inv_valid_o <= 1'b1;
              bus.dir_inv_pdt_o   <= (func3 == F3_PDT);
              bus.dir_inv_dv_o    <= cmd[33];
              bus.dir_inv_did_o   <= cmd[63:40];
              bus.dir_inv_pid_o   <= cmd[31:12];
            end else if (is_fence) begin
              bus.fence_valid_o <= 1'b1;
              bus.fence_av_o    <= cmd[10];
              bus.fence_wsi_o   <= cmd[11];
              bus.fence_pr_o    <= cmd[12];
              bus.fence_pw_o    <= cmd[13];
              bus.fence_data_o  <= cmd[63:32];
              // ADDR field is cmd[126:64]; the output is ADDR<<2 truncated to 64 bits.
              bus.fence_addr_o  <= {cmd[125:64], 2'b00};
            end else begin
              state         <= HALT;
              bus.cmd_ill_o <= 1'b1;
            end
          end
        end
        DISPATCH: begin
          if (dispatch_hs) begin
            state            <= IDLE;
            bus.beat_ready_o <= 1'b1;
            bus.busy_o       <= 1'b0;
            bus.cmd_done_o   <= 1'b1;
          end
        end
        HALT: begin
          if (bus.cmd_ill_clr_i) begin
            state            <= IDLE;
            bus.cmd_ill_o    <= 1'b0;
            bus.beat_ready_o <= 1'b1;
            bus.busy_o       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iommu_cq_decoder.sv
// Bench for iommu_cq_decoder: directed command scenarios plus random commands
// checked against a field-extraction reference model.
module tb_iommu_cq_decoder;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  iommu_cq_decoder_if bus ();
  iommu_cq_decoder dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  typedef struct {
    int          kind;  // 0 illegal, 1 iotlb, 2 dir, 3 fence
    bit          gvma, tav, pscv, gv;
    bit [19:0]   pscid;
    bit [15:0]   gscid;
    bit [51:0]   vpn;
    bit          pdt, dv;
    bit [23:0]   did;
    bit [19:0]   pid;
    bit          fav, wsi, pr, pw;
    bit [63:0]   faddr;
    bit [31:0]   fdata;
  } exp_t;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int cyc = 0;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (bus.cmd_done_o === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] fld(input logic [127:0] c, input int lo, input int w);
    logic [127:0] m;
    m = (128'd1 << w) - 128'd1;
    return 64'((c >> lo) & m);
  endfunction

  // Reference decode straight from the command-format rules.
  function automatic exp_t model(input logic [127:0] c);
    exp_t e;
    int   op, f3;
    e  = '{default: 0};
    op = int'(fld(c, 0, 7));
    f3 = int'(fld(c, 7, 3));
    if (op == 1 && (f3 == 0 || (f3 == 1 && fld(c, 32, 1) == 0))) begin
      e.kind  = 1;
      e.gvma  = (f3 == 1);
      e.tav   = fld(c, 10, 1) != 0;
      e.pscv  = fld(c, 32, 1) != 0;
      e.gv    = fld(c, 33, 1) != 0;
      e.pscid = 20'(fld(c, 12, 20));
      e.gscid = 16'(fld(c, 44, 16));
      e.vpn   = 52'(fld(c, 74, 52));
    end else if (op == 3 && (f3 == 0 || (f3 == 1 && fld(c, 33, 1) == 1))) begin
      e.kind = 2;
      e.pdt  = (f3 == 1);
      e.dv   = fld(c, 33, 1) != 0;
      e.did  = 24'(fld(c, 40, 24));
      e.pid  = 20'(fld(c, 12, 20));
    end else if (op == 2 && f3 == 0) begin
      e.kind  = 3;
      e.fav   = fld(c, 10, 1) != 0;
      e.wsi   = fld(c, 11, 1) != 0;
      e.pr    = fld(c, 12, 1) != 0;
      e.pw    = fld(c, 13, 1) != 0;
      e.fdata = 32'(fld(c, 32, 32));
      e.faddr = fld(c, 64, 63) * 64'd4;
    end
    return e;
  endfunction

  task automatic check_outputs(input exp_t e);
    check("iotlb_valid", 64'(bus.iotlb_inv_valid_o), 64'(e.kind == 1));
    check("iotlb_gvma",  64'(bus.iotlb_inv_gvma_o),  64'(e.gvma));
    check("iotlb_av",    64'(bus.iotlb_inv_av_o),    64'(e.tav));
    check("iotlb_pscv",  64'(bus.iotlb_inv_pscv_o),  64'(e.pscv));
    check("iotlb_gv",    64'(bus.iotlb_inv_gv_o),    64'(e.gv));
    check("iotlb_pscid", 64'(bus.iotlb_inv_pscid_o), 64'(e.pscid));
    check("iotlb_gscid", 64'(bus.iotlb_inv_gscid_o), 64'(e.gscid));
    check("iotlb_vpn",   64'(bus.iotlb_inv_vpn_o),   64'(e.vpn));
    check("dir_valid",   64'(bus.dir_inv_valid_o),   64'(e.kind == 2));
    check("dir_pdt",     64'(bus.dir_inv_pdt_o),     64'(e.pdt));
    check("dir_dv",      64'(bus.dir_inv_dv_o),      64'(e.dv));
    check("dir_did",     64'(bus.dir_inv_did_o),     64'(e.did));
    check("dir_pid",     64'(bus.dir_inv_pid_o),     64'(e.pid));
    check("fence_valid", 64'(bus.fence_valid_o),     64'(e.kind == 3));
    check("fence_av",    64'(bus.fence_av_o),        64'(e.fav));
    check("fence_wsi",   64'(bus.fence_wsi_o),       64'(e.wsi));
    check("fence_pr",    64'(bus.fence_pr_o),        64'(e.pr));
    check("fence_pw",    64'(bus.fence_pw_o),        64'(e.pw));
    check("fence_addr",  bus.fence_addr_o,           e.faddr);
    check("fence_data",  64'(bus.fence_data_o),      64'(e.fdata));
  endtask

  // Returns one cycle after the beat1 handshake edge.
  task automatic push_beats(input logic [63:0] lo, input logic [63:0] hi);
    int n;
    n = 0;
    bus.beat_valid_i = 1'b1;
    bus.beat_data_i  = lo;
    while (bus.beat_ready_o !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    check("beat0_ready", 64'(bus.beat_ready_o), 64'd1);
    tick;
    check("beat1_ready", 64'(bus.beat_ready_o), 64'd1);
    check("beat1_busy",  64'(bus.busy_o),       64'd1);
    bus.beat_data_i = hi;
    tick;
    bus.beat_valid_i = 1'b0;
    bus.beat_data_i  = {$urandom(), $urandom()};
  endtask

  task automatic run_cmd(input logic [63:0] lo, input logic [63:0] hi, input int stall);
    exp_t e;
    exp_t z;
    e = model({hi, lo});
    z = '{default: 0};
    push_beats(lo, hi);
    check_outputs(e);
    check("disp_ready", 64'(bus.beat_ready_o), 64'd0);
    check("disp_busy",  64'(bus.busy_o),       64'd1);
    check("ill_flag",   64'(bus.cmd_ill_o),    64'(e.kind == 0));
    if (e.kind != 0) begin
      // Readies of idle channels must be ignored.
      bus.iotlb_inv_ready_i = (e.kind != 1) && $urandom_range(0, 1) == 1;
      bus.dir_inv_ready_i   = (e.kind != 2) && $urandom_range(0, 1) == 1;
      bus.fence_ready_i     = (e.kind != 3) && $urandom_range(0, 1) == 1;
      repeat (stall) begin
        tick;
        check_outputs(e);
        check("stall_ready", 64'(bus.beat_ready_o), 64'd0);
        check("stall_done",  64'(bus.cmd_done_o),   64'd0);
      end
      bus.iotlb_inv_ready_i = (e.kind == 1);
      bus.dir_inv_ready_i   = (e.kind == 2);
      bus.fence_ready_i     = (e.kind == 3);
      tick;
      bus.iotlb_inv_ready_i = 1'b0;
      bus.dir_inv_ready_i   = 1'b0;
      bus.fence_ready_i     = 1'b0;
      exp_done++;
      check("done_pulse", 64'(bus.cmd_done_o),   64'd1);
      check("post_ready", 64'(bus.beat_ready_o), 64'd1);
      check("post_busy",  64'(bus.busy_o),       64'd0);
      check_outputs(z);
    end else begin
      bus.beat_valid_i = 1'b1;
      repeat (stall) begin
        tick;
        check("halt_ill",   64'(bus.cmd_ill_o),    64'd1);
        check("halt_ready", 64'(bus.beat_ready_o), 64'd0);
        check("halt_busy",  64'(bus.busy_o),       64'd1);
      end
      bus.beat_valid_i  = 1'b0;
      bus.cmd_ill_clr_i = 1'b1;
      tick;
      bus.cmd_ill_clr_i = 1'b0;
      check("clr_ill",   64'(bus.cmd_ill_o),    64'd0);
      check("clr_ready", 64'(bus.beat_ready_o), 64'd1);
      check("clr_busy",  64'(bus.busy_o),       64'd0);
      check_outputs(z);
    end
  endtask

  initial begin
    exp_t        z;
    int          d0;
    int          c0;
    logic [63:0] lo;
    logic [63:0] hi;
    int          r;
    z = '{default: 0};
    bus.beat_valid_i      = 1'b0;
    bus.beat_data_i       = '0;
    bus.iotlb_inv_ready_i = 1'b0;
    bus.dir_inv_ready_i   = 1'b0;
    bus.fence_ready_i     = 1'b0;
    bus.cmd_ill_clr_i     = 1'b0;

    repeat (3) tick;
    rst_i = 1'b0;
    check("rst_ready", 64'(bus.beat_ready_o), 64'd1);
    check("rst_busy",  64'(bus.busy_o),       64'd0);
    check("rst_ill",   64'(bus.cmd_ill_o),    64'd0);
    check("rst_done",  64'(bus.cmd_done_o),   64'd0);
    check_outputs(z);

    // IOTINVAL.VMA with 5 cycles of backpressure, literal expectations.
    push_beats(64'h0000_0001_1234_5401, 64'h400);
    check("vma_valid", 64'(bus.iotlb_inv_valid_o), 64'd1);
    check("vma_gvma",  64'(bus.iotlb_inv_gvma_o),  64'd0);
    check("vma_av",    64'(bus.iotlb_inv_av_o),    64'd1);
    check("vma_pscv",  64'(bus.iotlb_inv_pscv_o),  64'd1);
    check("vma_pscid", 64'(bus.iotlb_inv_pscid_o), 64'h12345);
    check("vma_vpn",   64'(bus.iotlb_inv_vpn_o),   64'h1);
    d0 = done_cnt;
    repeat (5) begin
      tick;
      check("bp_valid", 64'(bus.iotlb_inv_valid_o), 64'd1);
      check("bp_pscid", 64'(bus.iotlb_inv_pscid_o), 64'h12345);
      check("bp_vpn",   64'(bus.iotlb_inv_vpn_o),   64'h1);
      check("bp_ready", 64'(bus.beat_ready_o),      64'd0);
      check("bp_busy",  64'(bus.busy_o),            64'd1);
      check("bp_done",  64'(bus.cmd_done_o),        64'd0);
    end
    bus.iotlb_inv_ready_i = 1'b1;
    tick;
    bus.iotlb_inv_ready_i = 1'b0;
    exp_done++;
    check("vma_done",  64'(bus.cmd_done_o),        64'd1);
    check("vma_clear", 64'(bus.iotlb_inv_valid_o), 64'd0);
    tick;
    check("vma_done_once", 64'(done_cnt - d0), 64'd1);
    check("vma_done_low",  64'(bus.cmd_done_o), 64'd0);

    run_cmd(64'hABCD_EF02_0000_0003, 64'h0, 1);
    run_cmd(64'hDEAD_BEEF_0000_0C02, 64'h1000, 0);
    run_cmd(64'h83, 64'h0, 3);
    run_cmd(64'h0000_0001_1234_5401, 64'h400, 0);

    // Back-to-back legal commands at full rate.
    c0 = cyc;
    run_cmd(64'hDEAD_BEEF_0000_0C02, 64'h1000, 0);
    run_cmd(64'hABCD_EF02_0000_0003, 64'h0, 0);
    check("throughput_cycles", 64'(cyc - c0), 64'd6);

    // Reset after beat0: the next two beats form a fresh command.
    bus.beat_valid_i = 1'b1;
    bus.beat_data_i  = 64'hDEAD_BEEF_0000_0C02;
    tick;
    bus.beat_valid_i = 1'b0;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    check("midrst_ready", 64'(bus.beat_ready_o), 64'd1);
    check("midrst_busy",  64'(bus.busy_o),       64'd0);
    run_cmd(64'h0000_0001_1234_5401, 64'h400, 1);

    // Reset in DISPATCH with ready high: no completion.
    push_beats(64'hABCD_EF02_0000_0003, 64'h0);
    check("dsp_valid", 64'(bus.dir_inv_valid_o), 64'd1);
    d0 = done_cnt;
    bus.dir_inv_ready_i = 1'b1;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    bus.dir_inv_ready_i = 1'b0;
    check("dsprst_done",  64'(bus.cmd_done_o),   64'd0);
    check("dsprst_ready", 64'(bus.beat_ready_o), 64'd1);
    check("dsprst_busy",  64'(bus.busy_o),       64'd0);
    check_outputs(z);
    tick;
    check("dsprst_nodone", 64'(done_cnt - d0), 64'd0);

    // Reset while halted on ATS.
    push_beats(64'h4, 64'h0);
    check("ats_ill",   64'(bus.cmd_ill_o),    64'd1);
    check("ats_ready", 64'(bus.beat_ready_o), 64'd0);
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    check("haltrst_ill",   64'(bus.cmd_ill_o),    64'd0);
    check("haltrst_ready", 64'(bus.beat_ready_o), 64'd1);

    for (int i = 0; i < 150; i++) begin
      lo = {$urandom(), $urandom()};
      hi = {$urandom(), $urandom()};
      r  = int'($urandom_range(0, 9));
      if (r < 3)      lo[6:0] = 7'd1;
      else if (r < 6) lo[6:0] = 7'd3;
      else if (r < 8) lo[6:0] = 7'd2;
      else            lo[6:0] = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 9) < 7) lo[9:7] = 3'($urandom_range(0, 1));
      else                          lo[9:7] = 3'($urandom_range(0, 7));
      run_cmd(lo, hi, int'($urandom_range(0, 3)));
    end

    repeat (2) tick;
    check("done_count", 64'(done_cnt), 64'(exp_done));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iommu_cq_decoder.md
IOMMU_CQ_DECODER -- requirements
Module: iommu_cq_decoder

Interface
REQ-001 SHALL have parameters: none; all field widths are fixed by the CQ command formats (128-bit command, 64-bit beats).
REQ-002 SHALL have port `clk_i` (in, 1): sole clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst_i` (in, 1): reset, synchronous and active-high.
REQ-004 SHALL have ports `beat_valid_i` (in, 1), `beat_data_i` (in, 64), `beat_ready_o` (out, 1): command stream, two beats per command, bits [63:0] first, then [127:64].
REQ-005 SHALL have IOTLB invalidation ports:
- `iotlb_inv_valid_o` (out, 1), `iotlb_inv_ready_i` (in, 1)
- `iotlb_inv_gvma_o` (out, 1), `iotlb_inv_av_o` (out, 1), `iotlb_inv_pscv_o` (out, 1), `iotlb_inv_gv_o` (out, 1)
- `iotlb_inv_pscid_o` (out, 20), `iotlb_inv_gscid_o` (out, 16), `iotlb_inv_vpn_o` (out, 52)
REQ-006 SHALL have directory-cache invalidation ports:
- `dir_inv_valid_o` (out, 1), `dir_inv_ready_i` (in, 1)
- `dir_inv_pdt_o` (out, 1), `dir_inv_dv_o` (out, 1)
- `dir_inv_did_o` (out, 24), `dir_inv_pid_o` (out, 20)
REQ-007 SHALL have fence ports:
- `fence_valid_o` (out, 1), `fence_ready_i` (in, 1); ready means all prior work drained and the fence side effects are done.
- `fence_av_o`, `fence_wsi_o`, `fence_pr_o`, `fence_pw_o` (out, 1 each)
- `fence_addr_o` (out, 64): command ADDR<<2.
- `fence_data_o` (out, 32).
REQ-008 SHALL have status ports:
- `cmd_done_o` (out, 1): one-cycle pulse per completed command.
- `cmd_ill_o` (out, 1): sticky illegal-command flag.
- `cmd_ill_clr_i` (in, 1): clears `cmd_ill_o`.
- `busy_o` (out, 1): high when state != IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, BEAT1, DISPATCH, HALT.
REQ-010 SHALL assert `beat_ready_o` only in IDLE and BEAT1.
- IDLE: a handshake stores the low dword and moves to BEAT1.
- BEAT1: a handshake stores the high dword and moves to DISPATCH or HALT per REQ-012.
REQ-011 SHALL decode fields from the assembled 128-bit word:
- Common: opcode[6:0], func3[9:7].
- IOTINVAL: av[10], pscid[31:12], pscv[32], gv[33], gscid[59:44], addr[125:74].
- IOFENCE: av[10], wsi[11], pr[12], pw[13], data[63:32], addr[126:64].
- IODIR: pid[31:12], dv[33], did[63:40].
- Reserved bits are ignored.
REQ-012 SHALL treat a command as illegal (go to HALT, no output valid) when any of the following holds:
- opcode is not in {1, 2, 3}; ATS (opcode 4) is illegal.
- IOTINVAL func3 is not in {VMA, GVMA}.
- IOTINVAL.GVMA has pscv=1.
- IODIR func3 is not in {DDT, PDT}.
- IODIR.PDT has dv=0.
- IOFENCE func3 != 0.
REQ-013 SHALL register the decoded fields on the BEAT1 handshake, and in DISPATCH assert exactly one valid (iotlb/dir/fence) starting the cycle after that handshake.
REQ-014 SHALL hold the valid and all payload outputs stable until the matching ready is high; on handshake it returns to IDLE and pulses `cmd_done_o` in the following cycle.
REQ-015 SHALL drive `iotlb_inv_gvma_o` = (func3==GVMA), `dir_inv_pdt_o` = (func3==PDT), and all payload outputs to 0 whenever their valid is low.
REQ-016 SHALL provide minimum throughput of one command per 3 cycles: a new beat0 may be accepted in the cycle after the dispatch handshake.
REQ-017 SHALL handle HALT as follows:
- Set `cmd_ill_o`=1 on entry and hold it.
- Accept no beats.
- `cmd_ill_clr_i`=1 clears `cmd_ill_o` and returns to IDLE next cycle.
- `cmd_ill_clr_i` is ignored outside HALT.
REQ-018 SHALL ignore ready inputs when the matching valid is low.

Reset
REQ-019 SHALL on `rst_i`=1 at a clock edge enter IDLE, discard any partially assembled command, and clear the stored dwords.
REQ-020 SHALL have reset values: all valids=0, `cmd_done_o`=0, `cmd_ill_o`=0, `busy_o`=0, all payload outputs=0; `beat_ready_o`=1 in the first cycle after reset release.
REQ-021 SHALL let reset override every other input, including reset asserted in DISPATCH with ready=1 and during HALT; no `cmd_done_o` pulse is produced.

Verification
REQ-022 SHALL cover these directed scenarios:
- IOTINVAL.VMA: beats 0x0000_0001_1234_5401, 0x400 -> `iotlb_inv_valid_o`=1 one cycle after beat1; gvma=0, av=1, pscv=1, pscid=0x12345, vpn=0x1; `cmd_done_o` pulse after handshake.
- IODIR.DDT: beats 0xABCD_EF02_0000_0003, 0x0 -> `dir_inv_valid_o`=1, pdt=0, dv=1, did=0xABCDEF.
- IOFENCE: beats 0xDEAD_BEEF_0000_0C02, 0x1000 -> `fence_valid_o`=1, av=1, wsi=1, pr=pw=0, data=0xDEADBEEF, addr=0x4000.
- IODIR.PDT with dv=0: beats 0x83, 0x0 -> no valid; `cmd_ill_o`=1 and `beat_ready_o`=0 until `cmd_ill_clr_i` pulses, then IDLE; next legal command decodes correctly.
- Backpressure: `iotlb_inv_ready_i` low for 5 cycles -> valid and payload stable, `beat_ready_o`=0, `busy_o`=1, exactly one `cmd_done_o`.
- Reset mid-command: beat0 accepted, then `rst_i` pulse -> next two beats are assembled as a fresh command.
